// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter sizing helper shared by serial_adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int ceil_log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational D-bit ripple-carry slice of full adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module digit_adder #(
   parameter int D = 1
) (
   input  logic [D-1:0] i_a,
   input  logic [D-1:0] i_b,
   input  logic         i_c,
   output logic [D-1:0] o_s,
   output logic         o_c,
   output logic         o_c_msb
);

   logic [D:0] w_c;

   assign w_c[0] = i_c;

   for (genvar i = 0; i < D; i++) begin : g_fa
      assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_c     = w_c[D];
   assign o_c_msb = w_c[D-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: N-bit adder processing D bits per clock, LSB digit first, with valid/ready handshake.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port (A - B - ~carry_in).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_carry_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic         i_sub,
`endif
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_s,
   output logic         o_carry_out,
   output logic         o_ovf
);

   localparam int L  = N / D;
   localparam int CW = (ceil_log2(L) > 1) ? ceil_log2(L) : 1;

   if (N < 1 || D < 1 || D > N || N % D != 0) begin : g_bad_params
      $error("serial_adder: need 1 <= D <= N and N %% D == 0");
   end

   state_t          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_a, r_b, r_s, w_s_next;
   logic            r_c, r_ovf;
   logic            w_sub, w_last, w_co, w_cmsb;
   logic [D-1:0]    w_sum;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = i_sub;
`else
   assign w_sub = 1'b0;
`endif

   digit_adder #(.D(D)) u_digit (
      .i_a    (r_a[D-1:0]),
      .i_b    (r_b[D-1:0]),
      .i_c    (r_c),
      .o_s    (w_sum),
      .o_c    (w_co),
      .o_c_msb(w_cmsb)
   );

   // New sum digits enter the result register from the MSB side.
   if (D == N) begin : g_full
      assign w_s_next = w_sum;
   end else begin : g_part
      assign w_s_next = {w_sum, r_s[N-1:D]};
   end

   assign w_last = r_cnt == CW'(L - 1);

   always_ff @(posedge i_clk) begin
      r_state <= i_rst ? IDLE : w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_valid ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         DONE:    w_next = i_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_s   <= '0;
         r_c   <= 1'b0;
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && i_valid) begin
         r_a   <= i_a;
         r_b   <= w_sub ? ~i_b : i_b;
         r_c   <= i_carry_in;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_a   <= r_a >> D;
         r_b   <= r_b >> D;
         r_s   <= w_s_next;
         r_c   <= w_co;
         r_cnt <= r_cnt + 1'b1;
         // Only the final digit's MSB carries determine signed overflow.
         if (w_last) r_ovf <= w_cmsb ^ w_co;
      end
   end

   assign o_ready     = r_state == IDLE;
   assign o_valid     = r_state == DONE;
   assign o_s         = r_s;
   assign o_carry_out = r_c;
   assign o_ovf       = r_ovf;

endmodule
